// File: rtl/cut_sweep_ctrl.sv
// rtl/cut_sweep_ctrl.sv - sweeps a vector range through the cut, counting f=1 and compacting f into a CRC signature
module cut_sweep_ctrl #(
  parameter int          IN_W   = 11,
  parameter int          SETTLE = 1,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter int          CNT_W  = IN_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  cfg_first,
  input  logic [IN_W-1:0]  cfg_last,
  output logic [IN_W-1:0]  cut_in,
  input  logic             cut_f,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] ones_count,
  output logic [15:0]      sig
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_SAMPLE, S_DONE} state_e;

  localparam logic [3:0]       WAIT_INIT = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [IN_W-1:0]  V_ONE     = 1;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  v_q, v_d;
  logic [IN_W-1:0]  last_q, last_d;
  logic [IN_W-1:0]  cut_in_q, cut_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sig_q, sig_d;
  logic [3:0]       wait_q, wait_d;
  logic             aborted_q, aborted_d;
  logic             fb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      v_q       <= '0;
      last_q    <= '0;
      cut_in_q  <= '0;
      cnt_q     <= '0;
      sig_q     <= 16'h0000;
      wait_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      last_q    <= last_d;
      cut_in_q  <= cut_in_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      wait_q    <= wait_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    last_d    = last_q;
    cut_in_d  = cut_in_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    wait_d    = wait_q;
    aborted_d = 1'b0;
    fb        = sig_q[15] ^ cut_f;

    case (state_q)
      S_IDLE: begin
        // abort outranks start, so a coincident request is dropped
        if (start && !abort) begin
          v_d     = cfg_first;
          last_d  = cfg_last;
          cnt_d   = '0;
          sig_d   = 16'hFFFF;
          state_d = (cfg_first > cfg_last) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        cut_in_d = v_q;
        wait_d   = WAIT_INIT;
        state_d  = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_SAMPLE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_SAMPLE: begin
        sig_d = {sig_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        if (cut_f) cnt_d = cnt_q + CNT_ONE;
        // compare before increment so an all-ones last vector never wraps
        if (v_q == last_q) begin
          state_d = S_DONE;
        end else begin
          v_d     = v_q + V_ONE;
          state_d = S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // a cancelled sweep keeps whatever partial results it had reached
    if (state_q != S_IDLE && abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      v_d       = v_q;
      cut_in_d  = cut_in_q;
      cnt_d     = cnt_q;
      sig_d     = sig_q;
      wait_d    = wait_q;
    end
  end

  assign cut_in     = cut_in_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !abort;
  assign aborted    = aborted_q;
  assign ones_count = cnt_q;
  assign sig        = sig_q;

endmodule
